// File: rtl/add_arbiter_if.sv
// add_arbiter_if: request/operand/response bundle for the shared-adder arbiter.
// slave is the arbiter's view, master is the requester/consumer view.
interface add_arbiter_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned NREQ  = 3
);
    logic [NREQ-1:0]  req;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [WIDTH-1:0] a2;
    logic [WIDTH-1:0] b2;
    logic [NREQ-1:0]  gnt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [WIDTH-1:0] sum;
    logic             overflow;
    logic             ovf_clr;
    logic             ovf_sticky;

    modport slave (
        input  req, a0, b0, a1, b1, a2, b2, rsp_ready, ovf_clr,
        output gnt, rsp_valid, rsp_id, sum, overflow, ovf_sticky
    );

    modport master (
        output req, a0, b0, a1, b1, a2, b2, rsp_ready, ovf_clr,
        input  gnt, rsp_valid, rsp_id, sum, overflow, ovf_sticky
    );
endinterface

// File: rtl/add_arbiter.sv
// add_arbiter: one WIDTH-bit two's-complement adder shared by three requesters
// through a round-robin arbiter, with a single registered result slot.
// Grant is combinational; the result (sum/overflow/rsp_id/rsp_valid) is
// registered with one cycle of latency and supports back-to-back issue.
// Optional feature: define ADD_ARB_STICKY_OVF_EN to enable the sticky overflow
// flag (ovf_sticky / ovf_clr); otherwise ovf_sticky is tied low.
module add_arbiter #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned NREQ  = 3
) (
    input logic          clk,
    input logic          rst_n,
    add_arbiter_if.slave bus
);
    localparam int unsigned IDW = 2;
    localparam int unsigned MSB = WIDTH - 1;

    logic [IDW-1:0]   last_grant;
    logic             free_c;
    logic             found_c;
    logic [IDW-1:0]   cand_c;
    logic [IDW-1:0]   win_c;
    logic [NREQ-1:0]  gnt_c;
    logic [WIDTH-1:0] a_c;
    logic [WIDTH-1:0] b_c;
    logic [WIDTH-1:0] sum_c;
    logic             ovf_c;

    // Round-robin search from last_grant+1; only when the result slot is free
    // and never while reset is asserted.
    always_comb begin
        found_c = 1'b0;
        cand_c  = '0;
        win_c   = '0;
        gnt_c   = '0;
        free_c  = !bus.rsp_valid || bus.rsp_ready;
        if (rst_n && free_c) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                cand_c = IDW'((32'(last_grant) + 32'd1 + k) % NREQ);
                if (!found_c && bus.req[cand_c]) begin
                    found_c = 1'b1;
                    win_c   = cand_c;
                end
            end
        end
        if (found_c) begin
            gnt_c[win_c] = 1'b1;
        end
    end

    assign bus.gnt = gnt_c;

    // Operand select for the winner, shared adder and signed-overflow detect.
    always_comb begin
        a_c = bus.a0;
        b_c = bus.b0;
        case (win_c)
            IDW'(1): begin
                a_c = bus.a1;
                b_c = bus.b1;
            end
            IDW'(2): begin
                a_c = bus.a2;
                b_c = bus.b2;
            end
            default: begin
                a_c = bus.a0;
                b_c = bus.b0;
            end
        endcase
        sum_c = a_c + b_c;
        ovf_c = (a_c[MSB] == b_c[MSB]) && (sum_c[MSB] != a_c[MSB]);
    end

    // Result slot: load on grant, otherwise drain when the consumer accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= 1'b0;
            bus.sum       <= '0;
            bus.overflow  <= 1'b0;
            bus.rsp_id    <= '0;
            last_grant    <= IDW'(NREQ - 1);
        end else if (found_c) begin
            bus.rsp_valid <= 1'b1;
            bus.sum       <= sum_c;
            bus.overflow  <= ovf_c;
            bus.rsp_id    <= win_c;
            last_grant    <= win_c;
        end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end

`ifdef ADD_ARB_STICKY_OVF_EN
    // Sticky overflow: sets alongside any overflowing load; set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ovf_sticky <= 1'b0;
        end else if (found_c && ovf_c) begin
            bus.ovf_sticky <= 1'b1;
        end else if (bus.ovf_clr) begin
            bus.ovf_sticky <= 1'b0;
        end
    end
`else
    logic unused_ovf_clr;

    // Sticky overflow disabled: status tied low, clear input has no effect.
    assign bus.ovf_sticky = 1'b0;
    assign unused_ovf_clr = bus.ovf_clr;
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed self-checking bench for add_arbiter.
module tb_add_arbiter;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned NREQ  = 3;

`ifdef ADD_ARB_STICKY_OVF_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    logic [2:0]  rr_gnt [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [1:0]  rr_id  [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [63:0] rr_sum [6] = '{64'd3, 64'd30, 64'd300, 64'd3, 64'd30, 64'd300};

    always #5 clk = ~clk;

    add_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    add_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.req       = 3'b001;
        bus.a0        = '0;
        bus.b0        = '0;
        bus.a1        = '0;
        bus.b1        = '0;
        bus.a2        = '0;
        bus.b2        = '0;
        bus.rsp_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        // Reset state, with a request present that must not be granted
        chk("rst_valid",  64'(bus.rsp_valid),  64'd0);
        chk("rst_sum",    bus.sum,             64'd0);
        chk("rst_ovf",    64'(bus.overflow),   64'd0);
        chk("rst_id",     64'(bus.rsp_id),     64'd0);
        chk("rst_gnt",    64'(bus.gnt),        64'd0);
        chk("rst_sticky", 64'(bus.ovf_sticky), 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 3'b000;

        // Single request: 620 + (-34) = 586
        @(negedge clk);
        bus.req       = 3'b001;
        bus.a0        = 64'd620;
        bus.b0        = -64'sd34;
        bus.rsp_ready = 1'b1;
        #1 chk("single_gnt", 64'(bus.gnt), 64'b001);
        @(posedge clk); #1;
        chk("single_valid", 64'(bus.rsp_valid), 64'd1);
        chk("single_id",    64'(bus.rsp_id),    64'd0);
        chk("single_sum",   bus.sum,            64'd586);
        chk("single_ovf",   64'(bus.overflow),  64'd0);

        // Positive overflow on requester 1
        @(negedge clk);
        bus.req = 3'b010;
        bus.a1  = 64'h7FFF_FFFF_FFFF_FFFF;
        bus.b1  = 64'd1;
        #1 chk("povf_gnt", 64'(bus.gnt), 64'b010);
        @(posedge clk); #1;
        chk("povf_sum", bus.sum,           64'h8000_0000_0000_0000);
        chk("povf_ovf", 64'(bus.overflow), 64'd1);
        chk("povf_id",  64'(bus.rsp_id),   64'd1);

        // Negative overflow on requester 2, back to back
        @(negedge clk);
        bus.req = 3'b100;
        bus.a2  = 64'h8000_0000_0000_0000;
        bus.b2  = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 chk("novf_gnt", 64'(bus.gnt), 64'b100);
        @(posedge clk); #1;
        chk("novf_sum",    bus.sum,             64'h7FFF_FFFF_FFFF_FFFF);
        chk("novf_ovf",    64'(bus.overflow),   64'd1);
        chk("novf_id",     64'(bus.rsp_id),     64'd2);
        chk("novf_sticky", 64'(bus.ovf_sticky), 64'(STK));

        // Drain and clear sticky overflow
        @(negedge clk);
        bus.req     = 3'b000;
        bus.ovf_clr = 1'b1;
        #1 chk("idle_gnt", 64'(bus.gnt), 64'b000);
        @(posedge clk); #1;
        chk("drain_valid", 64'(bus.rsp_valid),  64'd0);
        chk("clr_sticky",  64'(bus.ovf_sticky), 64'd0);

        // Round robin with all three requesting (last grant was 2)
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        bus.req     = 3'b111;
        bus.a0 = 64'd1;   bus.b0 = 64'd2;
        bus.a1 = 64'd10;  bus.b1 = 64'd20;
        bus.a2 = 64'd100; bus.b2 = 64'd200;
        for (int i = 0; i < 6; i++) begin
            #1 chk($sformatf("rr_gnt%0d", i), 64'(bus.gnt), 64'(rr_gnt[i]));
            @(posedge clk); #1;
            chk($sformatf("rr_valid%0d", i), 64'(bus.rsp_valid), 64'd1);
            chk($sformatf("rr_id%0d", i),    64'(bus.rsp_id),    64'(rr_id[i]));
            chk($sformatf("rr_sum%0d", i),   bus.sum,            rr_sum[i]);
            @(negedge clk);
        end
        bus.req = 3'b000;
        #1 chk("rr_end_gnt", 64'(bus.gnt), 64'b000);
        @(posedge clk); #1;
        chk("rr_end_valid", 64'(bus.rsp_valid), 64'd0);

        // Backpressure: one grant, then held for three stalled cycles
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req       = 3'b011;
        bus.a0 = 64'd5; bus.b0 = 64'd6;
        bus.a1 = 64'd7; bus.b1 = 64'd8;
        #1 chk("bp_gnt0", 64'(bus.gnt), 64'b001);
        @(posedge clk); #1;
        chk("bp_sum0", bus.sum,         64'd11);
        chk("bp_id0",  64'(bus.rsp_id), 64'd0);
        @(negedge clk);
        bus.req = 3'b010;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("bp_stall_gnt%0d", i), 64'(bus.gnt), 64'b000);
            @(posedge clk); #1;
            chk($sformatf("bp_hold_sum%0d", i),   bus.sum,            64'd11);
            chk($sformatf("bp_hold_id%0d", i),    64'(bus.rsp_id),    64'd0);
            chk($sformatf("bp_hold_valid%0d", i), 64'(bus.rsp_valid), 64'd1);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        #1 chk("bp_gnt1", 64'(bus.gnt), 64'b010);
        @(posedge clk); #1;
        chk("bp_sum1", bus.sum,         64'd15);
        chk("bp_id1",  64'(bus.rsp_id), 64'd1);
        @(negedge clk);
        bus.req = 3'b000;
        @(posedge clk); #1;
        chk("bp_end_valid", 64'(bus.rsp_valid), 64'd0);

        // Reset mid-operation with a pending result and pending requests
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req       = 3'b001;
        bus.a0 = 64'd40; bus.b0 = 64'd2;
        #1 chk("mr_gnt0", 64'(bus.gnt), 64'b001);
        @(posedge clk); #1;
        chk("mr_sum0", bus.sum, 64'd42);
        @(negedge clk);
        bus.req = 3'b110;
        bus.a1 = 64'd3; bus.b1 = 64'd4;
        bus.a2 = 64'd9; bus.b2 = 64'd9;
        #1 chk("mr_stall_gnt", 64'(bus.gnt), 64'b000);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mr_sum",   bus.sum,            64'd0);
        chk("mr_id",    64'(bus.rsp_id),    64'd0);
        chk("mr_ovf",   64'(bus.overflow),  64'd0);
        chk("mr_gnt",   64'(bus.gnt),       64'b000);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;
        #1 chk("mr_first_gnt", 64'(bus.gnt), 64'b010);
        @(posedge clk); #1;
        chk("mr_first_id",  64'(bus.rsp_id), 64'd1);
        chk("mr_first_sum", bus.sum,         64'd7);
        @(negedge clk);
        bus.req = 3'b100;
        #1 chk("mr_second_gnt", 64'(bus.gnt), 64'b100);
        @(posedge clk); #1;
        chk("mr_second_sum", bus.sum, 64'd18);
        @(negedge clk);
        bus.req = 3'b000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
